// File: rtl/keypad_entry.sv
// Keypad entry front end: collects up to four BCD digits, submits on '*', clears on '#',
// on inactivity timeout, or on alert. All outputs come straight from registers.
module keypad_entry #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned HOLD_CYCLES    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        alert,
    output logic [15:0] display,
    output logic        star,
    output logic [2:0]  digit_cnt,
    output logic        short_entry,
    output logic        timeout
);

    typedef enum logic [1:0] {StIdle, StEntry, StSubmit, StHold} state_t;

    // Expiry compares the pre-increment count so the pulse lands TIMEOUT_CYCLES-1 cycles
    // after the last key.
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 2);
    localparam logic [7:0]  HoldLast    = 8'(HOLD_CYCLES - 1);

    state_t      state;
    logic [15:0] idle_cnt;
    logic [7:0]  hold_cnt;

    logic is_digit;
    logic is_star;
    logic is_hash;

    assign is_digit = (key_code <= 4'd9);
    assign is_star  = (key_code == 4'd10);
    assign is_hash  = (key_code == 4'd11);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            display     <= 16'h0000;
            digit_cnt   <= 3'd0;
            star        <= 1'b0;
            short_entry <= 1'b0;
            timeout     <= 1'b0;
            idle_cnt    <= 16'd0;
            hold_cnt    <= 8'd0;
        end else begin
            star        <= 1'b0;
            short_entry <= 1'b0;
            timeout     <= 1'b0;
            if (alert) begin
                state     <= StIdle;
                display   <= 16'h0000;
                digit_cnt <= 3'd0;
                idle_cnt  <= 16'd0;
                hold_cnt  <= 8'd0;
            end else begin
                case (state)
                    StIdle: begin
                        if (key_valid && is_digit) begin
                            display   <= {12'h000, key_code};
                            digit_cnt <= 3'd1;
                            idle_cnt  <= 16'd0;
                            state     <= StEntry;
                        end
                    end
                    StEntry: begin
                        if (key_valid) begin
                            // Any key, reserved codes included, counts as activity.
                            idle_cnt <= 16'd0;
                            if (is_digit) begin
                                if (digit_cnt != 3'd4) begin
                                    display   <= {display[11:0], key_code};
                                    digit_cnt <= digit_cnt + 3'd1;
                                end
                            end else if (is_star) begin
                                if (digit_cnt == 3'd4) begin
                                    star  <= 1'b1;
                                    state <= StSubmit;
                                end else begin
                                    display     <= 16'h0000;
                                    digit_cnt   <= 3'd0;
                                    short_entry <= 1'b1;
                                    state       <= StIdle;
                                end
                            end else if (is_hash) begin
                                display   <= 16'h0000;
                                digit_cnt <= 3'd0;
                                state     <= StIdle;
                            end
                        end else if (idle_cnt == TimeoutLast) begin
                            display   <= 16'h0000;
                            digit_cnt <= 3'd0;
                            timeout   <= 1'b1;
                            idle_cnt  <= 16'd0;
                            state     <= StIdle;
                        end else begin
                            idle_cnt <= idle_cnt + 16'd1;
                        end
                    end
                    StSubmit: begin
                        hold_cnt <= 8'd0;
                        state    <= StHold;
                    end
                    StHold: begin
                        if (hold_cnt == HoldLast) begin
                            display   <= 16'h0000;
                            digit_cnt <= 3'd0;
                            hold_cnt  <= 8'd0;
                            state     <= StIdle;
                        end else begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: inputs change on the falling edge, outputs are
// checked on the falling edge after the rising edge that consumed them.
module tb_keypad_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'd0;
    logic        alert = 1'b0;
    logic [15:0] display;
    logic        star;
    logic [2:0]  digit_cnt;
    logic        short_entry;
    logic        timeout;

    int errors = 0;
    int checks = 0;
    int star_hi = 0;

    keypad_entry #(
        .TIMEOUT_CYCLES(10),
        .HOLD_CYCLES   (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alert      (alert),
        .display    (display),
        .star       (star),
        .digit_cnt  (digit_cnt),
        .short_entry(short_entry),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (star) star_hi++;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [15:0] exp_disp,
                             input logic [2:0] exp_cnt, input logic exp_star,
                             input logic exp_short, input logic exp_to);
        check({tag, ".display"}, display, exp_disp);
        check({tag, ".digit_cnt"}, 16'(digit_cnt), 16'(exp_cnt));
        check({tag, ".star"}, 16'(star), 16'(exp_star));
        check({tag, ".short_entry"}, 16'(short_entry), 16'(exp_short));
        check({tag, ".timeout"}, 16'(timeout), 16'(exp_to));
    endtask

    // Called at a falling edge; returns at the falling edge after the key is consumed.
    task automatic press(input logic [3:0] code);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all("reset", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);

        // 1,2,3,4,'*' submit and hold
        press(4'd1);
        check_all("d1", 16'h0001, 3'd1, 1'b0, 1'b0, 1'b0);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        check_all("d1234", 16'h1234, 3'd4, 1'b0, 1'b0, 1'b0);
        press(4'd10);
        check_all("submit", 16'h1234, 3'd4, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_all("hold", 16'h1234, 3'd4, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        check_all("hold_end", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        check("star_once", 16'(star_hi), 16'd1);

        // 5,6,'*' short entry
        press(4'd5);
        press(4'd6);
        check_all("d56", 16'h0056, 3'd2, 1'b0, 1'b0, 1'b0);
        press(4'd10);
        check_all("short", 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_all("short_end", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);

        // 1,2,3,4,9,'*': fifth digit dropped; key during HOLD ignored
        press(4'd1);
        press(4'd2);
        press(4'd3);
        press(4'd4);
        press(4'd9);
        check_all("d12349", 16'h1234, 3'd4, 1'b0, 1'b0, 1'b0);
        press(4'd10);
        check_all("submit2", 16'h1234, 3'd4, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        press(4'd5);
        check_all("hold_key", 16'h1234, 3'd4, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_all("hold_end2", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        check("star_twice", 16'(star_hi), 16'd2);

        // Timeout 9 cycles after key 7
        press(4'd7);
        check_all("d7", 16'h0007, 3'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("pre_timeout", 16'(timeout), 16'd0);
        end
        @(negedge clk);
        check_all("timeout", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_all("timeout_end", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);

        // Key 8 on the expiry cycle wins over timeout
        press(4'd7);
        repeat (8) @(negedge clk);
        press(4'd8);
        check_all("expiry_key", 16'h0078, 3'd2, 1'b0, 1'b0, 1'b0);

        // '#' clears without pulse
        press(4'd11);
        check_all("hash", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);

        // Alert clears and blocks keys
        press(4'd1);
        press(4'd2);
        check_all("d12", 16'h0012, 3'd2, 1'b0, 1'b0, 1'b0);
        alert = 1'b1;
        @(negedge clk);
        check_all("alert", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        press(4'd3);
        press(4'd4);
        press(4'd10);
        check_all("alert_keys", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        alert = 1'b0;
        @(negedge clk);
        check("star_after_alert", 16'(star_hi), 16'd2);

        // Reset mid-entry beats a simultaneous key
        press(4'd1);
        press(4'd2);
        press(4'd3);
        check_all("d123", 16'h0123, 3'd3, 1'b0, 1'b0, 1'b0);
        rst       = 1'b1;
        key_valid = 1'b1;
        key_code  = 4'd4;
        @(negedge clk);
        rst       = 1'b0;
        key_valid = 1'b0;
        check_all("rst_key", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        press(4'd11);
        check_all("idle_hash", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
KEYPAD_ENTRY -- requirements
Module: keypad_entry

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning ENTRY-state idle cycles before auto-clear (legal range 2..65535).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4, meaning cycles display is held after a submit (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port key_valid  input  1  one-cycle strobe marking key_code valid.
REQ-006 SHALL have port key_code  input  4  key code: 0-9 digit, 10 '*', 11 '#', 12-15 reserved.
REQ-007 SHALL have port alert  input  1  alarm active from comparator stage; blocks entry.
REQ-008 SHALL have port display  output  16  four BCD digits, most recent digit in [3:0].
REQ-009 SHALL have port star  output  1  one-cycle submit pulse to comparator stage.
REQ-010 SHALL have port digit_cnt  output  3  digits entered, 0..4.
REQ-011 SHALL have port short_entry  output  1  one-cycle pulse: '*' rejected with 1..3 digits.
REQ-012 SHALL have port timeout  output  1  one-cycle pulse: entry auto-cleared by inactivity.

Function
REQ-013 SHALL implement states IDLE, ENTRY, SUBMIT, HOLD.
REQ-014 IDLE: display=0, digit_cnt=0. Digit key -> display={12'h000,digit}, digit_cnt=1, go ENTRY. '*', '#', reserved codes -> ignored.
REQ-015 ENTRY, digit key, digit_cnt<4 -> display={display[11:0],digit}, digit_cnt+1.
REQ-016 ENTRY, digit key, digit_cnt==4 -> ignored, display unchanged, timeout counter restarted.
REQ-017 ENTRY, '*', digit_cnt==4 -> go SUBMIT; star=1 for exactly the SUBMIT cycle, display stable through that cycle.
REQ-018 ENTRY, '*', digit_cnt 1..3 -> display=0, digit_cnt=0, short_entry=1 for one cycle, go IDLE; star stays 0.
REQ-019 ENTRY, '#' -> display=0, digit_cnt=0, go IDLE; no pulse.
REQ-020 ENTRY: 16-bit idle counter cleared on any valid key (reserved codes included); at TIMEOUT_CYCLES-1 with no key -> display=0, digit_cnt=0, timeout=1 one cycle, go IDLE.
REQ-021 Key and timeout expiry in same cycle -> key processed, counter restarts, no timeout pulse.
REQ-022 SUBMIT lasts exactly one cycle, then HOLD.
REQ-023 HOLD: display and digit_cnt held for HOLD_CYCLES cycles, then display=0, digit_cnt=0, go IDLE.
REQ-024 All keys in SUBMIT and HOLD ignored; not queued.
REQ-025 alert=1 in any state -> next edge: display=0, digit_cnt=0, go IDLE, all pulses 0; keys ignored while alert=1.
REQ-026 alert rising during SUBMIT -> star already issued this cycle stays single; no re-issue.
REQ-027 star, short_entry and timeout mutually exclusive and never asserted for more than one consecutive cycle.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 rst=1 at a clock edge -> state IDLE, display=0, digit_cnt=0, star=0, short_entry=0, timeout=0, counters=0.
REQ-030 rst overrides alert and key_valid in the same cycle; reset mid-entry or mid-HOLD discards entry with no pulse.

Verification
REQ-031 Keys 1,2,3,4,'*' -> display 16'h1234, digit_cnt 4, star high exactly one cycle with display 16'h1234; display 0 after HOLD_CYCLES=4 more cycles.
REQ-032 Keys 5,6,'*' -> short_entry one cycle, star never high, display 0, digit_cnt 0.
REQ-033 Keys 1,2,3,4,9,'*' -> 9 ignored, star with display 16'h1234.
REQ-034 TIMEOUT_CYCLES=10, key 7 then none -> timeout pulse 9 cycles after the key, display 0; repeat with key 8 arriving at expiry cycle -> no timeout, display 16'h0078.
REQ-035 Keys 1,2 then alert=1 -> display 0 next edge; keys 3,4,'*' during alert -> ignored, star 0.
REQ-036 Keys 1,2,3 then rst=1 with key 4 same cycle -> all outputs 0; then '#' -> no change.
